// File: rtl/chnl_tx_pkt.sv
// Packet-aware buffered RIFFA TX channel: FWFT data FIFO plus segment-descriptor
// queue, cut into transfers on packet end, length cap or idle timeout.
module chnl_tx_pkt #(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int DEPTH            = 1024,
    parameter int SEGQ_DEPTH       = 8,
    parameter int CHNL_ALIGN       = 4,
    parameter int MAX_LENGTH       = 256,
    parameter int MAX_IDLE_CYCLES  = 128,
    parameter int HEADER           = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        i_val,
    output logic                        i_rdy,
    input  logic [C_PCI_DATA_WIDTH-1:0] i_data,
    input  logic                        i_last,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN,
    output logic                        o_busy,
    output logic [31:0]                 o_xfer_cnt
);
    localparam int W   = C_PCI_DATA_WIDTH;
    localparam int WPD = W / 32;
    localparam int AW  = CHNL_ALIGN / WPD;
    localparam int MW  = MAX_LENGTH / WPD;
    localparam int H   = HEADER * AW;
    localparam int PC  = MW - H;
    localparam int DW  = $clog2(DEPTH);
    localparam int QW  = $clog2(SEGQ_DEPTH);
    localparam int PW  = $clog2(MW + 1);
    localparam int IW  = (MAX_IDLE_CYCLES > 0) ? $clog2(MAX_IDLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_PAD} state_t;

    logic          unused_ack;
    assign unused_ack = CHNL_TX_ACK;

    logic [W-1:0]  dmem [DEPTH];
    logic [PW+1:0] qmem [SEGQ_DEPTH];
    logic [DW:0]   dwp_q, dwp_d, drp_q, drp_d;
    logic [QW:0]   qwp_q, qwp_d, qrp_q, qrp_d;
    logic          d_empty, d_full, q_empty, q_full;
    logic          d_push, d_pop, q_push, q_pop;
    logic [PW+1:0] q_wdata, qhead;

    logic          rdy_en_q, in_acc;
    logic [PW-1:0] seg_q, seg_d;
    logic [IW-1:0] idle_q, idle_d;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d, pad_q, pad_d, cnt_q, cnt_d, head_p, head_pad;
    logic [1:0]    rsn_q, rsn_d;
    logic [31:0]   len_q, len_d, xcnt_q, xcnt_d;
    logic [15:0]   seq_q, seq_d;
    logic          valid, xfer, done;
    logic [W-1:0]  data, hdr;
    logic [2:0]    flags;
    logic [63:0]   hdr_pair;

    assign d_empty = dwp_q == drp_q;
    assign d_full  = (dwp_q - drp_q) == (DW+1)'(DEPTH);
    assign q_empty = qwp_q == qrp_q;
    assign q_full  = (qwp_q - qrp_q) == (QW+1)'(SEGQ_DEPTH);

    // Readiness checks the descriptor queue too, so every accepted beat can push.
    assign i_rdy  = rdy_en_q & ~d_full & ~q_full;
    assign in_acc = i_val & i_rdy;
    assign d_push = in_acc;

    always_comb begin
        seg_d   = seg_q;
        idle_d  = idle_q;
        q_push  = 1'b0;
        q_wdata = '0;
        if (in_acc) begin
            idle_d = '0;
            if (i_last) begin
                q_push  = 1'b1;
                q_wdata = {seg_q + PW'(1), 2'b01};
                seg_d   = '0;
            end else if (seg_q + PW'(1) == PW'(PC)) begin
                q_push  = 1'b1;
                q_wdata = {PW'(PC), 2'b10};
                seg_d   = '0;
            end else begin
                seg_d = seg_q + PW'(1);
            end
        end else begin
            if (!i_val && idle_q != IW'(MAX_IDLE_CYCLES))
                idle_d = idle_q + IW'(1);
            if (MAX_IDLE_CYCLES != 0 && idle_q == IW'(MAX_IDLE_CYCLES) &&
                seg_q != '0 && !q_full) begin
                q_push  = 1'b1;
                q_wdata = {seg_q, 2'b11};
                seg_d   = '0;
                idle_d  = '0;
            end
        end
    end

    always_comb begin
        dwp_d = dwp_q + (DW+1)'(d_push);
        drp_d = drp_q + (DW+1)'(d_pop);
        qwp_d = qwp_q + (QW+1)'(q_push);
        qrp_d = qrp_q + (QW+1)'(q_pop);
    end

    always_ff @(posedge clk_i) begin
        if (d_push) dmem[dwp_q[DW-1:0]] <= i_data;
        if (q_push) qmem[qwp_q[QW-1:0]] <= q_wdata;
    end

    assign qhead    = qmem[qrp_q[QW-1:0]];
    assign head_p   = qhead[PW+1:2];
    assign head_pad = PW'((AW - (int'(head_p) % AW)) % AW);

    assign flags    = {rsn_q == 2'b11, rsn_q == 2'b10, rsn_q == 2'b01};
    assign hdr_pair = {29'b0, flags, seq_q, 16'(p_q * PW'(WPD))};

    // With a single lane per word the flags move to header word 1.
    always_comb begin
        hdr = '0;
        if (cnt_q == '0)
            hdr = (WPD >= 2) ? W'(hdr_pair) : W'(hdr_pair[31:0]);
        else if (WPD == 1 && cnt_q == PW'(1))
            hdr = W'(flags);
    end

    always_comb begin
        valid = 1'b0;
        data  = '0;
        case (state_q)
            S_HDR:  begin valid = 1'b1;     data = hdr;                   end
            S_DATA: begin valid = ~d_empty; data = dmem[drp_q[DW-1:0]];   end
            S_PAD:  valid = 1'b1;
            default: ;
        endcase
    end

    assign xfer  = valid & CHNL_TX_DATA_REN;
    assign d_pop = (state_q == S_DATA) & xfer;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        pad_d   = pad_q;
        rsn_d   = rsn_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        xcnt_d  = xcnt_q;
        q_pop   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (!q_empty) begin
                q_pop   = 1'b1;
                p_d     = head_p;
                pad_d   = head_pad;
                rsn_d   = qhead[1:0];
                len_d   = 32'(H * WPD) + 32'(head_p + head_pad) * 32'(WPD);
                cnt_d   = '0;
                state_d = (HEADER != 0) ? S_HDR : S_DATA;
            end
            S_HDR: if (xfer) begin
                if (cnt_q == PW'(AW - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else cnt_d = cnt_q + PW'(1);
            end
            S_DATA: if (xfer) begin
                if (cnt_q == p_q - PW'(1)) begin
                    cnt_d = '0;
                    if (pad_q != '0) state_d = S_PAD;
                    else             done    = 1'b1;
                end else cnt_d = cnt_q + PW'(1);
            end
            S_PAD: if (xfer) begin
                if (cnt_q == pad_q - PW'(1)) done = 1'b1;
                else                         cnt_d = cnt_q + PW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        if (done) begin
            state_d = S_IDLE;
            seq_d   = seq_q + 16'd1;
            xcnt_d  = xcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_en_q <= 1'b0;
            dwp_q    <= '0;
            drp_q    <= '0;
            qwp_q    <= '0;
            qrp_q    <= '0;
            seg_q    <= '0;
            idle_q   <= '0;
            state_q  <= S_IDLE;
            p_q      <= '0;
            pad_q    <= '0;
            rsn_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            seq_q    <= '0;
            xcnt_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            dwp_q    <= dwp_d;
            drp_q    <= drp_d;
            qwp_q    <= qwp_d;
            qrp_q    <= qrp_d;
            seg_q    <= seg_d;
            idle_q   <= idle_d;
            state_q  <= state_d;
            p_q      <= p_d;
            pad_q    <= pad_d;
            rsn_q    <= rsn_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            seq_q    <= seq_d;
            xcnt_q   <= xcnt_d;
        end
    end

    assign CHNL_TX            = state_q != S_IDLE;
    assign o_busy             = state_q != S_IDLE;
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_OFF        = '0;
    assign CHNL_TX_LEN        = len_q;
    assign CHNL_TX_DATA       = data;
    assign CHNL_TX_DATA_VALID = valid;
    assign o_xfer_cnt         = xcnt_q;
endmodule

// File: tb/tb_chnl_tx_pkt.sv
// Bench for chnl_tx_pkt: transaction-level model of segmenting and framing,
// checked word by word against the TX channel, plus literal directed checks.
module tb_chnl_tx_pkt;
    localparam int PC   = 6;
    localparam int MAXI = 16;

    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        i_val = 1'b0, i_last = 1'b0, i_rdy;
    logic [63:0] i_data = '0;
    logic        tx, ack = 1'b0, tlast, tvalid, ren = 1'b0, busy;
    logic [31:0] tlen, xcnt;
    logic [30:0] toff;
    logic [63:0] tdata;

    chnl_tx_pkt #(.C_PCI_DATA_WIDTH(64), .DEPTH(1024), .SEGQ_DEPTH(8), .CHNL_ALIGN(4),
                  .MAX_LENGTH(16), .MAX_IDLE_CYCLES(MAXI), .HEADER(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .i_val(i_val), .i_rdy(i_rdy), .i_data(i_data),
        .i_last(i_last), .CHNL_TX(tx), .CHNL_TX_ACK(ack), .CHNL_TX_LAST(tlast),
        .CHNL_TX_LEN(tlen), .CHNL_TX_OFF(toff), .CHNL_TX_DATA(tdata),
        .CHNL_TX_DATA_VALID(tvalid), .CHNL_TX_DATA_REN(ren), .o_busy(busy),
        .o_xfer_cnt(xcnt));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int ren_mode = 0;  // 0 hold low, 1 hold high, 2 random ~70% high

    always @(posedge clk) begin
        #1;
        ren = (ren_mode == 2) ? ($urandom_range(0, 9) < 7) : (ren_mode == 1);
    end

    typedef struct {
        logic [63:0] d;
        logic [31:0] len;
        int          kind;  // 0 header, 1 payload, 2 pad
        bit          last;
    } ew_t;

    ew_t         exp_q[$];
    ew_t         cur;
    logic [63:0] pend[$];
    logic [63:0] got_d[$];
    logic [31:0] got_len[$];
    int          idle_m = 0;
    int          xfers_m = 0;
    logic [15:0] seq_m = '0;
    bit          end_chk = 1'b0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] pat(int i);
        return 64'hD000_0000_0000_0000 + 64'(i);
    endfunction

    // Close the pending segment as one transfer with reason r (1 pkt, 2 cap, 3 idle).
    function automatic void emit(int r);
        int   p  = pend.size();
        int   pp = (p + 1) / 2 * 2;
        ew_t  w;
        logic [2:0] fl = (r == 1) ? 3'd1 : (r == 2) ? 3'd2 : 3'd4;
        w.len  = 32'((2 + pp) * 2);
        w.last = 1'b0;
        w.kind = 0;
        w.d    = {29'b0, fl, seq_m, 16'(p * 2)};
        exp_q.push_back(w);
        w.d = '0;
        exp_q.push_back(w);
        w.kind = 1;
        foreach (pend[i]) begin
            w.d = pend[i];
            exp_q.push_back(w);
        end
        w.kind = 2;
        w.d    = '0;
        for (int i = p; i < pp; i++) exp_q.push_back(w);
        exp_q[exp_q.size() - 1].last = 1'b1;
        seq_m++;
        xfers_m++;
        pend.delete();
    endfunction

    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            pend.delete();
            idle_m  = 0;
            seq_m   = '0;
            xfers_m = 0;
            end_chk = 1'b0;
        end else begin
            if (end_chk) begin
                chk("tx_low_after_last", 64'(tx), 64'd0);
                end_chk = 1'b0;
            end
            if (tx && exp_q.size() > 0 && exp_q[0].kind != 1)
                chk("valid_hold_hdr_pad", 64'(tvalid), 64'd1);
            if (tvalid && ren) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h with no transfer pending", tdata);
                end else begin
                    cur = exp_q.pop_front();
                    chk("tx_data", tdata, cur.d);
                    chk("tx_len", 64'(tlen), 64'(cur.len));
                    chk("tx_req", 64'({tx, tlast, toff}), {32'd0, 1'b1, 1'b1, 31'd0});
                    got_d.push_back(tdata);
                    got_len.push_back(tlen);
                    if (cur.last) end_chk = 1'b1;
                end
            end
            if (i_val && i_rdy) begin
                pend.push_back(i_data);
                idle_m = 0;
                if (i_last) emit(1);
                else if (pend.size() == PC) emit(2);
            end else if (idle_m == MAXI && pend.size() > 0) begin
                emit(3);
                idle_m = 0;
            end else if (!i_val && idle_m < MAXI) begin
                idle_m++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input bit last);
        bit acc = 1'b0;
        int n = 0;
        i_val = 1'b1; i_data = d; i_last = last;
        while (!acc && n < 5000) begin
            @(negedge clk);
            acc = i_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        i_val = 1'b0; i_last = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %h not accepted, expected acceptance", d);
        end
    endtask

    task automatic wait_tx(input int budget);
        int n = 0;
        while (!tx && n < budget) begin tick(); n++; end
        chk("tx_start", 64'(tx), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || tx) && n < budget) begin tick(); n++; end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        tick(); tick();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; ren_mode = 0; i_val = 1'b0; i_last = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        got_d.delete();
        got_len.delete();
    endtask

    logic [63:0] cap_hdr [4] = '{64'h0000_0002_0000_000C, 64'h0000_0002_0001_000C,
                                 64'h0000_0002_0002_000C, 64'h0000_0001_0003_0004};
    logic [31:0] cap_len [4] = '{32'd16, 32'd16, 32'd16, 32'd8};

    initial begin
        int acc, n, plen;
        repeat (2) @(negedge clk);
        chk("rst_tx", 64'(tx), 64'd0);
        chk("rst_valid", 64'(tvalid), 64'd0);
        chk("rst_len", 64'(tlen), 64'd0);
        chk("rst_data", tdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_xcnt", 64'(xcnt), 64'd0);
        chk("rst_rdy", 64'(i_rdy), 64'd0);
        do_reset();
        chk("rdy_after_rst", 64'(i_rdy), 64'd1);

        // 3-beat packet
        ren_mode = 1;
        for (int i = 0; i < 3; i++) send(pat(i), i == 2);
        @(negedge clk); chk("tx_before_desc", 64'(tx), 64'd0);
        @(negedge clk); chk("tx_rise", 64'(tx), 64'd1);
        chk("len_at_rise", 64'(tlen), 64'd12);
        drain(100);
        chk("t1_words", 64'(got_d.size()), 64'd6);
        chk("t1_hdr0", got_d[0], 64'h0000_0001_0000_0006);
        chk("t1_hdr1", got_d[1], 64'd0);
        for (int i = 0; i < 3; i++) chk("t1_data", got_d[2 + i], pat(i));
        chk("t1_pad", got_d[5], 64'd0);
        chk("t1_len", 64'(got_len[0]), 64'd12);
        chk("t1_xcnt", 64'(xcnt), 64'd1);

        // 20-beat packet split by the length cap
        do_reset();
        ren_mode = 2;
        for (int i = 0; i < 20; i++) send(pat(i), i == 19);
        drain(500);
        chk("t2_words", 64'(got_d.size()), 64'd28);
        for (int k = 0; k < 4; k++) begin
            chk("t2_hdr", got_d[8 * k], cap_hdr[k]);
            chk("t2_len", 64'(got_len[8 * k]), 64'(cap_len[k]));
        end
        for (int i = 0; i < 20; i++) chk("t2_order", got_d[(i / 6) * 8 + 2 + i % 6], pat(i));
        chk("t2_xcnt", 64'(xcnt), 64'd4);

        // 5 beats then idle flush
        do_reset();
        ren_mode = 1;
        for (int i = 0; i < 5; i++) send(pat(100 + i), 1'b0);
        wait_tx(60);
        drain(200);
        chk("t3_words", 64'(got_d.size()), 64'd8);
        chk("t3_hdr0", got_d[0], 64'h0000_0004_0000_000A);
        chk("t3_len", 64'(got_len[0]), 64'd16);
        chk("t3_last_data", got_d[6], pat(104));
        chk("t3_pad", got_d[7], 64'd0);

        // random packets with gaps on both sides
        do_reset();
        ren_mode = 2;
        for (int k = 0; k < 200; k++) begin
            plen = $urandom_range(1, 13);
            for (int j = 0; j < plen; j++) begin
                send({$urandom, $urandom}, j == plen - 1);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        drain(20000);
        chk("t4_xcnt", 64'(xcnt), 64'(xfers_m));

        // backpressure: descriptor queue fills first
        do_reset();
        acc = 0;
        i_val = 1'b1; i_last = 1'b0; i_data = pat(0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (i_rdy) acc++;
            @(posedge clk); #1;
            i_data = pat(acc);
        end
        #1;
        chk("bp_accepted", 64'(acc), 64'd54);
        chk("bp_rdy_low", 64'(i_rdy), 64'd0);
        ren_mode = 1;
        n = 0;
        while (acc < 1100 && n < 20000) begin
            i_last = (acc == 1099);
            @(negedge clk);
            if (i_rdy) acc++;
            @(posedge clk); #1;
            i_data = pat(acc);
            n++;
        end
        i_val = 1'b0; i_last = 1'b0;
        chk("bp_all_accepted", 64'(acc), 64'd1100);
        drain(20000);
        chk("bp_xfers", 64'(xcnt), 64'd184);

        // reset in the middle of the payload phase
        do_reset();
        for (int i = 0; i < 4; i++) send(pat(200 + i), i == 3);
        wait_tx(20);
        @(posedge clk); #3; ren_mode = 1;
        repeat (3) @(posedge clk);
        #3; ren_mode = 0;
        tick(); tick();
        chk("mid_in_xfer", 64'(tx), 64'd1);
        chk("mid_words", 64'(got_d.size()), 64'd3);
        @(posedge clk); #2;
        rst_ni = 1'b0;
        #1;
        chk("async_tx", 64'(tx), 64'd0);
        chk("async_valid", 64'(tvalid), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_len", 64'(tlen), 64'd0);
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        got_d.delete(); got_len.delete();
        ren_mode = 1;
        send(pat(300), 1'b1);
        wait_tx(20);
        drain(100);
        chk("t6_words", 64'(got_d.size()), 64'd4);
        chk("t6_hdr0", got_d[0], 64'h0000_0001_0000_0002);
        chk("t6_len", 64'(got_len[0]), 64'd8);
        chk("t6_data", got_d[2], pat(300));
        chk("t6_xcnt", 64'(xcnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
